// File: rtl/pr_pkg.sv
// Shared defaults and state encodings for the wide-line read/write buffers.
package pr_pkg;

   localparam int PR_FULL_WIDTH = 512;
   localparam int PR_WIDTH      = 64;
   localparam int PR_MAX_ELEMS  = PR_FULL_WIDTH / PR_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

endpackage

// File: rtl/write_buffer.sv
// Packs narrow elements into one wide memory write line over a slot range,
// then holds the line until the downstream write is accepted.
module write_buffer
   import pr_pkg::*;
#(
   parameter int FULL_WIDTH = PR_FULL_WIDTH,
   parameter int WIDTH      = PR_WIDTH,
   parameter int MAX_ELEMS  = FULL_WIDTH / WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ivalid,
   input  logic [WIDTH-1:0]      idata,
   output logic                  iready,
   input  logic [7:0]            base,
   input  logic [7:0]            bounds,
   input  logic                  flush,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [FULL_WIDTH-1:0] wdata,
   output logic [MAX_ELEMS-1:0]  wmask
);

   localparam logic [7:0] MAX8 = 8'(MAX_ELEMS);

   logic [1:0] state;
   logic [7:0] ptr;
   logic [7:0] end_q;

   logic       accept;
   logic       close;
   logic [7:0] st_c;
   logic [7:0] en_c;
   logic [7:0] slot;
   logic [7:0] lim;
   logic [7:0] nxt_ptr;

   assign iready = (state != ST_SEND);
   assign wvalid = (state == ST_SEND);
   assign accept = ivalid && iready;

   // First element of a line uses the clamped range directly.
   always_comb begin
      st_c    = (base < MAX8) ? base : 8'd0;
      en_c    = (bounds < MAX8) ? bounds : MAX8;
      slot    = (state == ST_IDLE) ? st_c : ptr;
      lim     = (state == ST_IDLE) ? en_c : end_q;
      nxt_ptr = slot + 8'd1;
      close   = (accept && ((nxt_ptr >= lim) || flush))
              || (flush && (state == ST_FILL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ptr   <= 8'd0;
         end_q <= 8'd0;
         wdata <= '0;
         wmask <= '0;
      end else begin
         if (accept) begin
            if (state == ST_IDLE)
               end_q <= en_c;
            ptr <= nxt_ptr;
            for (int k = 0; k < MAX_ELEMS; k++) begin
               if (slot == 8'(k)) begin
                  wdata[FULL_WIDTH-1-WIDTH*k -: WIDTH] <= idata;
                  wmask[k] <= 1'b1;
               end
            end
         end
         if (close)
            state <= ST_SEND;
         else if (accept)
            state <= ST_FILL;
         if ((state == ST_SEND) && wready) begin
            state <= ST_IDLE;
            ptr   <= 8'd0;
            wdata <= '0;
            wmask <= '0;
         end
      end
   end

endmodule

// File: tb/tb_write_buffer.sv
// Directed scoreboard bench for write_buffer.
// Expected lines are queued when driven and checked when wvalid rises.
module tb_write_buffer;

   localparam int FW = 512;
   localparam int W  = 64;
   localparam int ME = 8;

   typedef struct {
      logic [FW-1:0] data;
      logic [ME-1:0] mask;
   } line_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          ivalid;
   logic [W-1:0]  idata;
   logic          iready;
   logic [7:0]    base;
   logic [7:0]    bounds;
   logic          flush;
   logic          wvalid;
   logic          wready;
   logic [FW-1:0] wdata;
   logic [ME-1:0] wmask;

   int    total = 0;
   int    bad   = 0;
   line_t sb[$];
   line_t cur;

   write_buffer #(.FULL_WIDTH(FW), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata),
      .iready(iready), .base(base), .bounds(bounds), .flush(flush),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wmask(wmask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] obs,
                      input logic [FW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [W-1:0] d, input logic fl);
      ivalid = 1'b1;
      idata  = d;
      flush  = fl;
      tick();
      ivalid = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic exp_new();
      cur.data = '0;
      cur.mask = '0;
   endtask

   task automatic exp_put(input int k, input logic [W-1:0] d);
      cur.data[FW-1-W*k -: W] = d;
      cur.mask[k] = 1'b1;
   endtask

   task automatic finish_line(input string tag);
      line_t e;
      int n = 0;
      while (!wvalid && n < 4) begin
         tick();
         n++;
      end
      chk({tag, "_wvalid"}, wvalid, 1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_wdata"}, wdata, e.data);
         chk({tag, "_wmask"}, wmask, e.mask);
      end
      chk({tag, "_iready_send"}, iready, 0);
      wready = 1'b1;
      tick();
      wready = 1'b0;
      chk({tag, "_wvalid_clr"}, wvalid, 0);
      chk({tag, "_wmask_clr"}, wmask, 0);
      chk({tag, "_wdata_clr"}, wdata, 0);
   endtask

   initial begin
      logic [FW-1:0] hold_d;
      logic [ME-1:0] hold_m;
      rst = 1'b1; ivalid = 1'b0; idata = '0; base = 8'd0;
      bounds = 8'd8; flush = 1'b0; wready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_wvalid", wvalid, 0);
      chk("rst_wmask", wmask, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_iready", iready, 1);

      // full line
      base = 8'd0; bounds = 8'd8;
      exp_new();
      for (int i = 0; i < 8; i++) exp_put(i, 64'(8'h11 * (i + 1)));
      sb.push_back(cur);
      for (int i = 0; i < 8; i++) begin
         feed(64'(8'h11 * (i + 1)), 1'b0);
         if (i == 6) chk("full_early", wvalid, 0);
      end
      chk("full_lat", wvalid, 1);
      chk("full_top", wdata[511:448], 64'h11);
      chk("full_bot", wdata[63:0], 64'h88);
      finish_line("full");

      // partial range
      base = 8'd2; bounds = 8'd5;
      exp_new();
      exp_put(2, 64'hA); exp_put(3, 64'hB); exp_put(4, 64'hC);
      sb.push_back(cur);
      feed(64'hA, 1'b0); feed(64'hB, 1'b0); feed(64'hC, 1'b0);
      chk("part_lat", wvalid, 1);
      finish_line("part");

      // flush after 3 elements
      base = 8'd0; bounds = 8'd8;
      exp_new();
      for (int i = 0; i < 3; i++) exp_put(i, 64'(100 + i));
      sb.push_back(cur);
      for (int i = 0; i < 3; i++) feed(64'(100 + i), 1'b0);
      chk("flush_wait", wvalid, 0);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_lat", wvalid, 1);
      finish_line("flush");

      // flush with 3rd element
      sb.push_back(cur);
      feed(64'd100, 1'b0); feed(64'd101, 1'b0); feed(64'd102, 1'b1);
      chk("flush3_lat", wvalid, 1);
      finish_line("flush3");

      // flush alone in IDLE is ignored
      flush = 1'b1; tick(); flush = 1'b0; tick();
      chk("idle_flush", wvalid, 0);
      chk("idle_flush_rdy", iready, 1);

      // backpressure
      exp_new();
      for (int i = 0; i < 8; i++) exp_put(i, 64'(32'hBEEF0000 + i));
      sb.push_back(cur);
      for (int i = 0; i < 8; i++) feed(64'(32'hBEEF0000 + i), 1'b0);
      hold_d = cur.data;
      hold_m = cur.mask;
      for (int c = 0; c < 5; c++) begin
         ivalid = 1'b1;
         idata  = 64'($urandom);
         tick();
         chk("bp_data", wdata, hold_d);
         chk("bp_mask", wmask, hold_m);
         chk("bp_rdy", iready, 0);
      end
      ivalid = 1'b0;
      finish_line("bp");

      // clamp base and bounds
      base = 8'd9; bounds = 8'd12;
      exp_new();
      for (int i = 0; i < 8; i++) exp_put(i, 64'(i + 1));
      sb.push_back(cur);
      for (int i = 0; i < 8; i++) begin
         feed(64'(i + 1), 1'b0);
         if (i == 6) chk("clamp_early", wvalid, 0);
      end
      finish_line("clamp");

      // degenerate range
      base = 8'd5; bounds = 8'd3;
      exp_new();
      exp_put(5, 64'h55);
      sb.push_back(cur);
      feed(64'h55, 1'b0);
      chk("degen_lat", wvalid, 1);
      finish_line("degen");

      // reset mid-fill discards the line
      base = 8'd0; bounds = 8'd8;
      for (int i = 0; i < 4; i++) feed(64'(i + 7), 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mrst_wvalid", wvalid, 0);
      chk("mrst_wmask", wmask, 0);
      chk("mrst_rdy", iready, 1);
      base = 8'd3; bounds = 8'd5;
      exp_new();
      exp_put(3, 64'hD1); exp_put(4, 64'hD2);
      sb.push_back(cur);
      feed(64'hD1, 1'b0); feed(64'hD2, 1'b0);
      finish_line("mrst_new");

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter FULL_WIDTH, default 512, width of one wide memory write line.
REQ-002 SHALL have parameter WIDTH, default 64, width of one element.
REQ-003 SHALL derive MAX_ELEMS = FULL_WIDTH/WIDTH (8 at defaults).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 ivalid  input  1  element offered on idata.
REQ-008 idata  input  WIDTH  element payload.
REQ-009 iready  output  1  buffer accepts an element this cycle.
REQ-010 base  input  8  first slot index of the line, sampled with the first element of a line.
REQ-011 bounds  input  8  exclusive end slot index, sampled with base.
REQ-012 flush  input  1  close the partially filled line.
REQ-013 wvalid  output  1  wide write line is valid.
REQ-014 wready  input  1  downstream accepts the wide write.
REQ-015 wdata  output  FULL_WIDTH  packed line.
REQ-016 wmask  output  MAX_ELEMS  per-slot written flag, bit k = slot k.

Function
REQ-017 SHALL implement states IDLE (line empty), FILL (at least one slot written), SEND (wvalid high).
REQ-018 Slot k SHALL occupy wdata[FULL_WIDTH-1-WIDTH*k -: WIDTH], so slot 0 is the most significant element.
REQ-019 iready SHALL be 1 in IDLE and FILL and 0 in SEND; an element is accepted when ivalid && iready.
REQ-020 On acceptance in IDLE: start = (base < MAX_ELEMS) ? base : 0; end = min(bounds, MAX_ELEMS); both are latched; the element is written to slot start; the write pointer becomes start+1.
REQ-021 On acceptance in FILL: the element SHALL be written at the write pointer, its wmask bit set, and the pointer incremented.
REQ-022 If, after an acceptance, the pointer >= latched end, the state SHALL go to SEND on the next edge, so wvalid is high the cycle after the last accepted element.
REQ-023 If end <= start, the line SHALL close after its single first element.
REQ-024 flush in FILL SHALL move to SEND on the next edge; a simultaneous accepted element SHALL be included in the line.
REQ-025 flush in IDLE with no accepted element SHALL be ignored; flush in SEND SHALL have no effect.
REQ-026 flush in IDLE with a simultaneous accepted element SHALL send a one-element line.
REQ-027 In SEND, wdata and wmask SHALL be held stable until wvalid && wready.
REQ-028 On wvalid && wready: next state IDLE, wmask cleared to 0, wdata cleared to 0, wvalid low the next cycle.
REQ-029 Unwritten slots SHALL read as zero in wdata.
REQ-030 Pointer arithmetic SHALL be 8 bits wide; the pointer never indexes beyond MAX_ELEMS-1.

Reset
REQ-031 On rst: state IDLE, wvalid 0, wmask 0, wdata 0, pointer 0, latched start/end 0, iready 1 on the next cycle.
REQ-032 rst SHALL take priority over all other inputs, including mid-FILL or mid-SEND; a pending line is discarded.

Structure
REQ-033 FULL_WIDTH, WIDTH, MAX_ELEMS defaults and state encodings SHALL live in shared package pr_pkg, shared with the read-side buffer.
REQ-034 No sub-module is required; slot write-enable decode is inline.

Verification
REQ-035 Full line: base=0, bounds=8, 8 elements 0x11..0x88 back-to-back -> wvalid the cycle after the 8th element, wdata[511:448]=0x11, wdata[63:0]=0x88, wmask=0xFF.
REQ-036 Partial range: base=2, bounds=5, 3 elements A,B,C -> wmask=0x1C (bits 2,3,4), slots 2..4 hold A,B,C, other slots 0.
REQ-037 Flush: base=0, bounds=8, 3 elements, then flush -> wvalid next cycle, wmask=0x07; flush with ivalid on the 3rd element gives the same result.
REQ-038 Backpressure: wready held 0 for 5 cycles in SEND -> wdata/wmask stable, iready=0, ivalid ignored; wready=1 -> IDLE next cycle, wmask=0.
REQ-039 Clamp/degenerate: base=9 -> start slot 0; bounds=12 -> end 8; base=5, bounds=3 -> one-element line with wmask=0x20.
REQ-040 Reset mid-FILL after 4 elements -> wvalid 0, wmask 0, iready 1; the next line starts fresh at the new base.
